// File: rtl/matmul_pkg.sv
// Shared definitions for the sequential matrix multiplier.
//   state_t    : job controller states (IDLE / RUN / DONE)
//   acc_width  : accumulator width able to hold an M-term dot product
//   cnt_width  : counter width for an index range of n, at least 1 bit
package matmul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Two DW-bit products need 2*dw bits. Summing m of them adds clog2(m)
  // bits. One extra bit leaves room for the sign.
  function automatic int acc_width(input int dw, input int m);
    return 2 * dw + $clog2(m) + 1;
  endfunction

  // Width of an index counter over 0..n-1. A 1-entry range still gets a
  // 1-bit counter so that no zero-width vectors appear.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/matmul_seq_mac_lane.sv
// One multiply-accumulate lane of the sequential matrix multiplier.
//   a, b      : operand elements (DW bits)
//   is_signed : 1 = two's-complement operands, 0 = unsigned
//   acc_in    : running partial sum (AW bits)
//   acc_out   : acc_in + ext(a) * ext(b), wrapping modulo 2^AW
// The lane is purely combinational. The owning block holds the registers.
module mac_lane #(
  parameter int DW = 8,
  parameter int AW = 19
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          is_signed,
  input  logic [AW-1:0] acc_in,
  output logic [AW-1:0] acc_out
);

  logic [AW-1:0] a_ext;
  logic [AW-1:0] b_ext;
  logic [AW-1:0] prod;

  // Both operands are extended to the full accumulator width before the
  // multiply. The low AW bits of an AW x AW product are then correct for
  // both signed and unsigned operands, so one unsigned multiplier serves
  // both modes.
  always_comb begin
    a_ext   = is_signed ? {{(AW-DW){a[DW-1]}}, a} : {{(AW-DW){1'b0}}, a};
    b_ext   = is_signed ? {{(AW-DW){b[DW-1]}}, b} : {{(AW-DW){1'b0}}, b};
    prod    = a_ext * b_ext;
    acc_out = acc_in + prod;
  end

endmodule

// File: rtl/matmul_seq.sv
// Sequential matrix multiplier: C = A x B, or C += A x B.
// There are RIGHT_SIZE MAC lanes. Each lane owns one column of C. The lanes
// are stepped over the rows of A (i) and the inner dimension (k), one
// (i, k) pair per cycle.
//   clk, rst  : clock and synchronous active-high reset
//   start     : job request, taken only while idle
//   acc_en    : sampled with start; 1 = accumulate into result
//   is_signed : sampled with start; 1 = two's-complement operands
//   in1, in2  : matrices A[L][M] and B[M][R], captured on the accepted start
//   busy      : high while the MAC sweep runs
//   done      : one-cycle completion pulse
//   result    : matrix C[L][R], AW bits per element
module matmul_seq
  import matmul_pkg::*;
#(
  parameter int LEFT_SIZE   = 2,
  parameter int MIDDLE_SIZE = 3,
  parameter int RIGHT_SIZE  = 4,
  parameter int DW          = 8,
  parameter int AW          = acc_width(DW, MIDDLE_SIZE)
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic                                            start,
  input  logic                                            acc_en,
  input  logic                                            is_signed,
  input  logic [LEFT_SIZE-1:0][MIDDLE_SIZE-1:0][DW-1:0]   in1,
  input  logic [MIDDLE_SIZE-1:0][RIGHT_SIZE-1:0][DW-1:0]  in2,
  output logic                                            busy,
  output logic                                            done,
  output logic [LEFT_SIZE-1:0][RIGHT_SIZE-1:0][AW-1:0]    result
);

  localparam int RW = cnt_width(LEFT_SIZE);
  localparam int KW = cnt_width(MIDDLE_SIZE);
  localparam logic [RW-1:0] ROW_LAST = RW'(LEFT_SIZE - 1);
  localparam logic [KW-1:0] K_LAST   = KW'(MIDDLE_SIZE - 1);

  state_t state;
  state_t state_next;

  logic [LEFT_SIZE-1:0][MIDDLE_SIZE-1:0][DW-1:0]  a_reg;
  logic [MIDDLE_SIZE-1:0][RIGHT_SIZE-1:0][DW-1:0] b_reg;
  logic                                           signed_reg;
  logic [RW-1:0]                                  row;
  logic [KW-1:0]                                  k;
  logic                                           last_step;
  logic [RIGHT_SIZE-1:0][AW-1:0]                  lane_out;

  assign last_step = (row == ROW_LAST) && (k == K_LAST);

  // The lanes read the latched operands and the current row of result.
  // Lane j therefore produces the next value of result[row][j].
  for (genvar j = 0; j < RIGHT_SIZE; j++) begin : g_lane
    mac_lane #(
      .DW (DW),
      .AW (AW)
    ) u_lane (
      .a         (a_reg[row][k]),
      .b         (b_reg[k][j]),
      .is_signed (signed_reg),
      .acc_in    (result[row][j]),
      .acc_out   (lane_out[j])
    );
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake outputs. busy and done decode the state
  // directly. busy is therefore already low in the DONE cycle, and a start
  // held high is taken on the first IDLE cycle after DONE.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_step) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: capture the operands on an accepted start, then one (i, k)
  // step per RUN cycle. acc_en takes effect only at acceptance, where it
  // decides whether the old result is kept. That is why it is not held
  // for the rest of the job.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg      <= '0;
      b_reg      <= '0;
      signed_reg <= 1'b0;
      row        <= '0;
      k          <= '0;
      result     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg      <= in1;
            b_reg      <= in2;
            signed_reg <= is_signed;
            row        <= '0;
            k          <= '0;
            if (!acc_en) begin
              result <= '0;
            end
          end
        end
        RUN: begin
          for (int j = 0; j < RIGHT_SIZE; j++) begin
            result[row][j] <= lane_out[j];
          end
          if (k == K_LAST) begin
            k   <= '0;
            row <= (row == ROW_LAST) ? '0 : row + 1'b1;
          end else begin
            k <= k + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
